// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: controller states,
// ALU operations, opcodes and datapath mux selects. Used by the controller,
// datapath and ALU.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_ALU_WB    = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WB    = 4'd7,
    ST_MEM_WRITE = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_JALR      = 4'd11,
    ST_LINK      = 4'd12,
    ST_LUI       = 4'd13,
    ST_ILLEGAL   = 4'd14
  } state_t;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result bus selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  // Immediate format implied by the opcode; unknown opcodes default to I.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      OP_LUI:    sel = IMM_U;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder for R-type and I-type ALU instructions.
// Ports: rtype (1 = R-type, 0 = I-type), funct3, funct7 in;
//        alu_control (ALU op), legal (funct fields are supported) out.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       rtype,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    case (funct3)
      3'b000: begin
        legal = 1'b1;
        if (rtype && funct7[5]) alu_control = ALU_SUB;
      end
      3'b111: begin legal = 1'b1; alu_control = ALU_AND; end
      3'b110: begin legal = 1'b1; alu_control = ALU_OR;  end
      3'b010: begin legal = 1'b1; alu_control = ALU_SLT; end
      3'b100: begin legal = 1'b1; alu_control = ALU_XOR; end
      default: ;
    endcase
    // R-type: funct7 must be zero, with 0100000 allowed only for SUB.
    if (rtype) begin
      if (funct3 == 3'b000) legal = legal && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
      else                  legal = legal && (funct7 == 7'b0000000);
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM of the multi-cycle RV32I-subset core. Sequences fetch, decode,
// execute, memory and writeback and drives all datapath selects and enables.
// Ports: clk, rst (sync, active high), opcode/funct3/funct7 from IR, zero from
//        ALU in; pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
//        alu_src_a, alu_src_b, alu_control, result_src, instr_done, illegal,
//        state (debug) out.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic [2:0]         imm_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         result_src,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d, cur;
  logic [2:0] dec_alu;
  logic       dec_legal;

  alu_decoder u_alu_decoder (
    .rtype       (opcode == OP_R),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; DECODE dispatches and screens illegal encodings
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_R:      state_d = dec_legal ? ST_EXEC_R : ST_ILLEGAL;
          OP_IMM:    state_d = dec_legal ? ST_EXEC_I : ST_ILLEGAL;
          OP_LOAD,
          OP_STORE:  state_d = (funct3 == 3'b010) ? ST_MEM_ADDR : ST_ILLEGAL;
          OP_BRANCH: state_d = (funct3[2:1] == 2'b00) ? ST_BRANCH : ST_ILLEGAL;
          OP_JAL:    state_d = ST_JAL;
          OP_JALR:   state_d = (funct3 == 3'b000) ? ST_JALR : ST_ILLEGAL;
          OP_LUI:    state_d = ST_LUI;
          default:   state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ: state_d = ST_MEM_WB;
      ST_JAL:      state_d = ST_ALU_WB;
      ST_JALR:     state_d = ST_LINK;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Output decode; while in reset the FETCH decode is shown with writes held off
  always_comb begin
    cur         = rst ? ST_FETCH : state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    imm_src     = imm_sel(opcode);
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    result_src  = RES_ALUOUT;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (cur)
      ST_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        alu_control = dec_alu;
      end
      ST_EXEC_I: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
      end
      ST_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: adr_src = 1'b1;
      ST_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_SUB;
        // beq (funct3[0]=0) takes on zero, bne (funct3[0]=1) on not-zero
        pc_write    = zero ^ funct3[0];
        instr_done  = 1'b1;
      end
      ST_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      ST_JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
      end
      ST_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        illegal    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
    state = STATE_W'(cur);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of directed
// instructions, hand-written reset sequences and randomized instructions, all
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       zero = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [2:0] imm_src, alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       instr_done, illegal;
  logic [3:0] state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .imm_src(imm_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, memw, regw;
    logic [2:0] imm;
    logic [1:0] a, b;
    logic [2:0] alu;
    logic [1:0] res;
    logic       done, ill;
  } obs_t;

  typedef struct {
    string      tag;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    int         ncyc;
    logic       ill;
  } vec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  obs_t       exp_q[$];
  vec_t       tbl[$];
  logic [2:0] cur_imm;

  function automatic obs_t mk(input state_t s, input logic pcw, irw, adr, memw, regw,
                              input logic [1:0] a, b, input logic [2:0] alu,
                              input logic [1:0] res, input logic done, ill);
    obs_t o;
    o.st = 4'(s); o.pcw = pcw; o.irw = irw; o.adr = adr; o.memw = memw; o.regw = regw;
    o.imm = cur_imm; o.a = a; o.b = b; o.alu = alu; o.res = res; o.done = done; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.pcw = pc_write; o.irw = ir_write; o.adr = adr_src; o.memw = mem_write;
    o.regw = reg_write; o.imm = imm_src; o.a = alu_src_a; o.b = alu_src_b;
    o.alu = alu_control; o.res = result_src; o.done = instr_done; o.ill = illegal;
    return o;
  endfunction

  // {supported, op} for the funct3 map shared by R and I ALU instructions
  function automatic logic [3:0] alu_lookup(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b1000;
      3'b111:  return 4'b1010;
      3'b110:  return 4'b1011;
      3'b010:  return 4'b1100;
      3'b100:  return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model: expected per-cycle outputs of one whole instruction
  function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic z);
    logic       ok;
    logic [2:0] aop;
    logic [3:0] lk;
    ok = 1'b0;
    aop = 3'b000;
    case (op)
      7'b0100011: cur_imm = 3'b001;
      7'b1100011: cur_imm = 3'b010;
      7'b1101111: cur_imm = 3'b011;
      7'b0110111: cur_imm = 3'b100;
      default:    cur_imm = 3'b000;
    endcase
    exp_q.delete();
    exp_q.push_back(mk(ST_FETCH, H, H, L, L, L, 2'b00, 2'b10, 3'b000, 2'b10, L, L));
    exp_q.push_back(mk(ST_DECODE, L, L, L, L, L, 2'b01, 2'b01, 3'b000, 2'b00, L, L));
    case (op)
      7'b0110011: begin
        lk = alu_lookup(f3);
        if (f3 == 3'b000 && f7 == 7'b0100000) {ok, aop} = 4'b1001;
        else if (f7 == 7'b0000000)            {ok, aop} = lk;
        if (ok) begin
          exp_q.push_back(mk(ST_EXEC_R, L, L, L, L, L, 2'b10, 2'b00, aop, 2'b00, L, L));
          exp_q.push_back(mk(ST_ALU_WB, L, L, L, L, H, 2'b00, 2'b00, 3'b000, 2'b00, H, L));
        end
      end
      7'b0010011: begin
        {ok, aop} = alu_lookup(f3);
        if (ok) begin
          exp_q.push_back(mk(ST_EXEC_I, L, L, L, L, L, 2'b10, 2'b01, aop, 2'b00, L, L));
          exp_q.push_back(mk(ST_ALU_WB, L, L, L, L, H, 2'b00, 2'b00, 3'b000, 2'b00, H, L));
        end
      end
      7'b0000011: begin
        ok = (f3 == 3'b010);
        if (ok) begin
          exp_q.push_back(mk(ST_MEM_ADDR, L, L, L, L, L, 2'b10, 2'b01, 3'b000, 2'b00, L, L));
          exp_q.push_back(mk(ST_MEM_READ, L, L, H, L, L, 2'b00, 2'b00, 3'b000, 2'b00, L, L));
          exp_q.push_back(mk(ST_MEM_WB, L, L, L, L, H, 2'b00, 2'b00, 3'b000, 2'b01, H, L));
        end
      end
      7'b0100011: begin
        ok = (f3 == 3'b010);
        if (ok) begin
          exp_q.push_back(mk(ST_MEM_ADDR, L, L, L, L, L, 2'b10, 2'b01, 3'b000, 2'b00, L, L));
          exp_q.push_back(mk(ST_MEM_WRITE, L, L, H, H, L, 2'b00, 2'b00, 3'b000, 2'b00, H, L));
        end
      end
      7'b1100011: begin
        ok = (f3 == 3'b000 || f3 == 3'b001);
        // beq taken when equal, bne taken when not equal
        if (ok) exp_q.push_back(mk(ST_BRANCH, (f3 == 3'b000) ? z : !z, L, L, L, L,
                                   2'b10, 2'b00, 3'b001, 2'b00, H, L));
      end
      7'b1101111: begin
        ok = 1'b1;
        exp_q.push_back(mk(ST_JAL, H, L, L, L, L, 2'b01, 2'b10, 3'b000, 2'b00, L, L));
        exp_q.push_back(mk(ST_ALU_WB, L, L, L, L, H, 2'b00, 2'b00, 3'b000, 2'b00, H, L));
      end
      7'b1100111: begin
        ok = (f3 == 3'b000);
        if (ok) begin
          exp_q.push_back(mk(ST_JALR, H, L, L, L, L, 2'b10, 2'b01, 3'b000, 2'b10, L, L));
          exp_q.push_back(mk(ST_LINK, L, L, L, L, H, 2'b01, 2'b10, 3'b000, 2'b10, H, L));
        end
      end
      7'b0110111: begin
        ok = 1'b1;
        exp_q.push_back(mk(ST_LUI, L, L, L, L, H, 2'b00, 2'b00, 3'b000, 2'b11, H, L));
      end
      default: ok = 1'b0;
    endcase
    if (!ok) exp_q.push_back(mk(ST_ILLEGAL, L, L, L, L, L, 2'b00, 2'b00, 3'b000, 2'b00, H, H));
  endfunction

  task automatic check(input obs_t act, input obs_t exp, input string tag, input int cyc);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h (state %0d) expected %h (state %0d)",
               tag, cyc, act, act.st, exp, exp.st);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic resync();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Apply one instruction starting in FETCH; compare each cycle up to instr_done
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z,
                           output int ncyc, output logic saw_ill);
    obs_t act;
    int   base;
    logic fin;
    build(op, f3, f7, z);
    opcode = op; funct3 = f3; funct7 = f7; zero = z;
    base = n_fail; ncyc = 0; saw_ill = 1'b0; fin = 1'b0;
    for (int k = 0; k < 8 && !fin; k++) begin
      @(negedge clk);
      act = sample();
      if (k < exp_q.size()) check(act, exp_q[k], tag, k);
      if (illegal === 1'b1) saw_ill = 1'b1;
      if (instr_done === 1'b1) begin fin = 1'b1; ncyc = k + 1; end
      @(posedge clk); #1;
    end
    if (n_fail != base) resync();
  endtask

  function automatic void addv(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input int n, input logic ill);
    vec_t v;
    v.tag = tag; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.ncyc = n; v.ill = ill;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t       rexp;
    int         ncyc;
    logic       sill;
    logic [6:0] op, f7;
    logic [6:0] ops[8];

    addv("add",   7'b0110011, 3'b000, 7'b0000000, L, 4, L);
    addv("sub",   7'b0110011, 3'b000, 7'b0100000, L, 4, L);
    addv("and",   7'b0110011, 3'b111, 7'b0000000, L, 4, L);
    addv("slt",   7'b0110011, 3'b010, 7'b0000000, H, 4, L);
    addv("xori",  7'b0010011, 3'b100, 7'b1111111, L, 4, L);
    addv("ori",   7'b0010011, 3'b110, 7'b0100000, L, 4, L);
    addv("lw",    7'b0000011, 3'b010, 7'b0000000, L, 5, L);
    addv("sw",    7'b0100011, 3'b010, 7'b0000000, L, 4, L);
    addv("beq_z1", 7'b1100011, 3'b000, 7'b0000000, H, 3, L);
    addv("bne_z1", 7'b1100011, 3'b001, 7'b0000000, H, 3, L);
    addv("beq_z0", 7'b1100011, 3'b000, 7'b0000000, L, 3, L);
    addv("bne_z0", 7'b1100011, 3'b001, 7'b0000000, L, 3, L);
    addv("jal",   7'b1101111, 3'b101, 7'b1010101, L, 4, L);
    addv("jalr",  7'b1100111, 3'b000, 7'b0000000, L, 4, L);
    addv("lui",   7'b0110111, 3'b011, 7'b0000000, L, 3, L);
    addv("ill_op0",     7'b0000000, 3'b000, 7'b0000000, L, 3, H);
    addv("ill_r_f3_1",  7'b0110011, 3'b001, 7'b0000000, L, 3, H);
    addv("ill_lw_f3_0", 7'b0000011, 3'b000, 7'b0000000, L, 3, H);
    addv("ill_br_f3_4", 7'b1100011, 3'b100, 7'b0000000, H, 3, H);
    addv("ill_r_f7",    7'b0110011, 3'b000, 7'b0000001, L, 3, H);
    addv("ill_and_f7",  7'b0110011, 3'b111, 7'b0100000, L, 3, H);
    addv("ill_jalr_f3", 7'b1100111, 3'b001, 7'b0000000, L, 3, H);
    addv("ill_sw_f3",   7'b0100011, 3'b000, 7'b0000000, L, 3, H);
    addv("ill_slli",    7'b0010011, 3'b001, 7'b0000000, L, 3, H);

    // Reset held for 3 cycles: FETCH decode with all write enables low
    cur_imm = 3'b000;
    rexp = mk(ST_FETCH, L, L, L, L, L, 2'b00, 2'b10, 3'b000, 2'b10, L, L);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(sample(), rexp, "reset", i);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_instr(tbl[i].tag, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, ncyc, sill);
      check_val({tbl[i].tag, " cycles"}, 32'(ncyc), 32'(tbl[i].ncyc));
      check_val({tbl[i].tag, " illegal"}, 32'(sill), 32'(tbl[i].ill));
    end

    // Reset arriving in MEM_WRITE abandons the store
    build(7'b0100011, 3'b010, 7'b0000000, L);
    opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000; zero = L;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(sample(), exp_q[k], "sw_pre_rst", k);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    rexp = mk(ST_FETCH, L, L, L, L, L, 2'b00, 2'b10, 3'b000, 2'b10, L, L);
    @(negedge clk);
    check(sample(), rexp, "rst_in_mem_write", 3);
    check_val("mem_write_in_rst", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("sw_after_rst", 7'b0100011, 3'b010, 7'b0000000, L, ncyc, sill);
    check_val("sw_after_rst cycles", 32'(ncyc), 32'd4);

    // Randomized instructions against the model
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else                           op = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'b0000000;
        2:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      run_instr("random", op, 3'($urandom), f7, 1'($urandom), ncyc, sill);
      check_val("random cycles", 32'(ncyc), 32'(exp_q.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
